// File: rtl/axi4_lite_slv_template_pkg.sv
// Shared types and constants for the AXI4-Lite register block.
package axi4_lite_slv_template_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Register index width for a given register count (at least one bit).
  function automatic int unsigned reg_idx_width(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  localparam int unsigned DEFAULT_NUM_REGS = 4;
  localparam int unsigned REG_IDX_WIDTH    = reg_idx_width(DEFAULT_NUM_REGS);

  // Write channel progress: which of AW/W has been latched, or response pending.
  typedef enum logic [1:0] {
    StWrIdle,
    StWrAw,
    StWrW,
    StWrResp
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_slv_template_if.sv
// AXI4-Lite bundle with slave and master views.
interface axi4_lite_slv_template_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// Register storage: byte-strobed write port, asynchronous read port.
module axi4_lite_slv_reg_file #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Storage update: only strobed bytes of the addressed register change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int k = 0; k < DATA_WIDTH / 8; k++) begin
        if (wstrb[k]) regs[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = regs[ridx];

endmodule

// File: rtl/axi4_lite_slv_template.sv
// AXI4-Lite slave with a small bank of read/write registers; SLVERR outside the bank.
module axi4_lite_slv_template
  import axi4_lite_slv_template_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4
) (
  input logic                       i_clk,
  input logic                       i_sync_rst,
  axi4_lite_slv_template_if.slv_port if_s_axi4_lite
);

  localparam int unsigned IDX_W  = reg_idx_width(NUM_REGS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return a < ADDR_WIDTH'(NUM_REGS * 4);
  endfunction

  wr_state_e               wr_state_q, wr_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    bvalid_q;
  resp_t                   bresp_q;
  logic                    arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  resp_t                   rresp_q;

  logic                    aw_hs, w_hs, ar_hs, wr_fire, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data, rf_rdata;
  logic [STRB_W-1:0]       wr_strb;

  assign aw_hs = if_s_axi4_lite.awvalid && awready_q;
  assign w_hs  = if_s_axi4_lite.wvalid && wready_q;
  assign ar_hs = if_s_axi4_lite.arvalid && arready_q;

  // A channel completing this cycle bypasses its latch so the write can fire immediately.
  assign wr_addr = aw_hs ? if_s_axi4_lite.awaddr : aw_addr_q;
  assign wr_data = w_hs ? if_s_axi4_lite.wdata : w_data_q;
  assign wr_strb = w_hs ? if_s_axi4_lite.wstrb : w_strb_q;
  assign wr_ok   = addr_in_range(wr_addr);
  assign rd_ok   = addr_in_range(if_s_axi4_lite.araddr);

  // Write FSM next state; readys are registered from the next state.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_fire    = 1'b0;
    unique case (wr_state_q)
      StWrIdle: begin
        if (aw_hs && w_hs) begin
          wr_state_d = StWrResp;
          wr_fire    = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = StWrAw;
        end else if (w_hs) begin
          wr_state_d = StWrW;
        end
      end
      StWrAw: begin
        if (w_hs) begin
          wr_state_d = StWrResp;
          wr_fire    = 1'b1;
        end
      end
      StWrW: begin
        if (aw_hs) begin
          wr_state_d = StWrResp;
          wr_fire    = 1'b1;
        end
      end
      StWrResp: begin
        if (bvalid_q && if_s_axi4_lite.bready) wr_state_d = StWrIdle;
      end
      default: wr_state_d = StWrIdle;
    endcase
    awready_d = (wr_state_d == StWrIdle) || (wr_state_d == StWrW);
    wready_d  = (wr_state_d == StWrIdle) || (wr_state_d == StWrAw);
  end

  // Write FSM state, channel latches and B response.
  always_ff @(posedge i_clk or posedge i_sync_rst) begin
    if (i_sync_rst) begin
      wr_state_q <= StWrIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      if (aw_hs) aw_addr_q <= if_s_axi4_lite.awaddr;
      if (w_hs) begin
        w_data_q <= if_s_axi4_lite.wdata;
        w_strb_q <= if_s_axi4_lite.wstrb;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && if_s_axi4_lite.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: capture on AR handshake, hold until R handshake.
  always_ff @(posedge i_clk or posedge i_sync_rst) begin
    if (i_sync_rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (ar_hs) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_ok ? rf_rdata : '0;
      rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && if_s_axi4_lite.rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  axi4_lite_slv_reg_file #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_reg_file (
    .clk   (i_clk),
    .rst   (i_sync_rst),
    .we    (wr_fire && wr_ok),
    .widx  (wr_addr[IDX_W+1:2]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .ridx  (if_s_axi4_lite.araddr[IDX_W+1:2]),
    .rdata (rf_rdata)
  );

  assign if_s_axi4_lite.awready = awready_q;
  assign if_s_axi4_lite.wready  = wready_q;
  assign if_s_axi4_lite.bvalid  = bvalid_q;
  assign if_s_axi4_lite.bresp   = bresp_q;
  assign if_s_axi4_lite.arready = arready_q;
  assign if_s_axi4_lite.rvalid  = rvalid_q;
  assign if_s_axi4_lite.rdata   = rdata_q;
  assign if_s_axi4_lite.rresp   = rresp_q;

  // Protection attributes carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

endmodule

// File: tb/tb_axi4_lite_slv_template.sv
// Directed bench for the AXI4-Lite register block.
module tb_axi4_lite_slv_template;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  axi4_lite_slv_template_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if ();

  axi4_lite_slv_template #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (4)
  ) dut (
    .i_clk          (clk),
    .i_sync_rst     (rst),
    .if_s_axi4_lite (axi_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Both channels presented together; bready held high.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_now, w_now, got_b = 0;
    resp = 2'b11;
    axi_if.awaddr  = addr;
    axi_if.wdata   = data;
    axi_if.wstrb   = strb;
    axi_if.awvalid = 1'b1;
    axi_if.wvalid  = 1'b1;
    axi_if.bready  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (aw_done && w_done) break;
      aw_now = axi_if.awvalid && axi_if.awready;
      w_now  = axi_if.wvalid && axi_if.wready;
      @(posedge clk); #1;
      if (aw_now) begin axi_if.awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin axi_if.wvalid  = 1'b0; w_done  = 1; end
    end
    for (int c = 0; c < 50; c++) begin
      if (axi_if.bvalid) begin
        resp  = axi_if.bresp;
        got_b = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    axi_if.awvalid = 1'b0;
    axi_if.wvalid  = 1'b0;
    check("wr_b_seen", 32'(got_b), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0, got_r = 0, ar_now;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    axi_if.araddr  = addr;
    axi_if.arvalid = 1'b1;
    axi_if.rready  = 1'b1;
    for (int c = 0; c < 50 && !ar_done; c++) begin
      ar_now = axi_if.arready;
      @(posedge clk); #1;
      if (ar_now) begin axi_if.arvalid = 1'b0; ar_done = 1; end
    end
    for (int c = 0; c < 50; c++) begin
      if (axi_if.rvalid) begin
        data  = axi_if.rdata;
        resp  = axi_if.rresp;
        got_r = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    axi_if.arvalid = 1'b0;
    check("rd_r_seen", 32'(got_r), 32'd1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  logic [31:0] wr_vals [4];

  initial begin
    wr_vals[0] = 32'h1234_5678;
    wr_vals[1] = 32'h8765_4321;
    wr_vals[2] = 32'hABCD_EF01;
    wr_vals[3] = 32'h10FE_DCBA;
    axi_if.awaddr = '0; axi_if.awprot = '0; axi_if.awvalid = 1'b0;
    axi_if.wdata = '0; axi_if.wstrb = '0; axi_if.wvalid = 1'b0;
    axi_if.bready = 1'b1;
    axi_if.araddr = '0; axi_if.arprot = '0; axi_if.arvalid = 1'b0;
    axi_if.rready = 1'b1;

    // Reset for 20 cycles
    repeat (20) @(posedge clk);
    #1;
    check("rst_awready", 32'(axi_if.awready), 32'd0);
    check("rst_wready", 32'(axi_if.wready), 32'd0);
    check("rst_arready", 32'(axi_if.arready), 32'd0);
    check("rst_bvalid", 32'(axi_if.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi_if.rvalid), 32'd0);
    check("rst_bresp", 32'(axi_if.bresp), 32'd0);
    check("rst_rresp", 32'(axi_if.rresp), 32'd0);
    check("rst_rdata", axi_if.rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_awready", 32'(axi_if.awready), 32'd1);
    check("rel_wready", 32'(axi_if.wready), 32'd1);
    check("rel_arready", 32'(axi_if.arready), 32'd1);
    check("rel_bvalid", 32'(axi_if.bvalid), 32'd0);
    check("rel_rvalid", 32'(axi_if.rvalid), 32'd0);

    // Full-word writes then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(32'(i * 4), wr_vals[i], 4'hF, rsp);
      check("wr_bresp", 32'(rsp), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), rd, rsp);
      check("rd_rresp", 32'(rsp), 32'd0);
      check("rd_data", rd, wr_vals[i]);
    end

    // Partial strobe
    axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, rsp);
    axi_write(32'h4, 32'h0000_AAAA, 4'b0011, rsp);
    check("strb_bresp", 32'(rsp), 32'd0);
    axi_read(32'h4, rd, rsp);
    check("strb_data", rd, 32'hFFFF_AAAA);

    // AW three cycles ahead of W
    axi_if.awaddr  = 32'h8;
    axi_if.awvalid = 1'b1;
    axi_if.bready  = 1'b1;
    check("early_awready", 32'(axi_if.awready), 32'd1);
    @(posedge clk); #1;
    axi_if.awvalid = 1'b0;
    check("early_aw_drop", 32'(axi_if.awready), 32'd0);
    check("early_no_b0", 32'(axi_if.bvalid), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("early_no_b", 32'(axi_if.bvalid), 32'd0);
      check("early_aw_low", 32'(axi_if.awready), 32'd0);
    end
    axi_if.wdata  = 32'h55AA_55AA;
    axi_if.wstrb  = 4'hF;
    axi_if.wvalid = 1'b1;
    check("late_wready", 32'(axi_if.wready), 32'd1);
    @(posedge clk); #1;
    axi_if.wvalid = 1'b0;
    check("late_bvalid", 32'(axi_if.bvalid), 32'd1);
    check("late_bresp", 32'(axi_if.bresp), 32'd0);
    check("late_wready_low", 32'(axi_if.wready), 32'd0);
    @(posedge clk); #1;
    check("late_b_done", 32'(axi_if.bvalid), 32'd0);
    check("late_aw_back", 32'(axi_if.awready), 32'd1);
    axi_read(32'h8, rd, rsp);
    check("late_rd_data", rd, 32'h55AA_55AA);

    // Out of range
    axi_write(32'h10, 32'hCAFE_F00D, 4'hF, rsp);
    check("oor_bresp", 32'(rsp), 32'd2);
    axi_read(32'h10, rd, rsp);
    check("oor_rresp", 32'(rsp), 32'd2);
    check("oor_rdata", rd, 32'd0);
    wr_vals[1] = 32'hFFFF_AAAA;
    wr_vals[2] = 32'h55AA_55AA;
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), rd, rsp);
      check("oor_keep", rd, wr_vals[i]);
    end

    // Stalled B then reset
    axi_if.bready  = 1'b0;
    axi_if.awaddr  = 32'h0;
    axi_if.wdata   = 32'hDEAD_BEEF;
    axi_if.wstrb   = 4'hF;
    axi_if.awvalid = 1'b1;
    axi_if.wvalid  = 1'b1;
    @(posedge clk); #1;
    axi_if.awvalid = 1'b0;
    axi_if.wvalid  = 1'b0;
    repeat (5) begin
      check("stall_bvalid", 32'(axi_if.bvalid), 32'd1);
      check("stall_awready", 32'(axi_if.awready), 32'd0);
      check("stall_wready", 32'(axi_if.wready), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("async_bvalid", 32'(axi_if.bvalid), 32'd0);
    check("async_awready", 32'(axi_if.awready), 32'd0);
    axi_if.bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_no_b", 32'(axi_if.bvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), rd, rsp);
      check("post_rst_zero", rd, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slv_template.md
# axi4_lite_slv_template

AXI4-Lite slave holding a small bank of 32-bit read/write registers, used as the baseline register block for peripherals on an AXI4-Lite control bus. It sits behind an AXI pass-through/protocol-checker stage. It accepts single-beat writes with byte strobes and single-beat reads. It answers out-of-range accesses with SLVERR.

## Interface
- ADDR_WIDTH, 32: AXI4-Lite address width.
- DATA_WIDTH, 32: AXI4-Lite data width; must be 32.
- NUM_REGS, 4: number of registers, at byte offsets 0x0, 0x4, … (NUM_REGS-1)*4.

Ports:
- i_clk  input  1  sole clock; all state changes on its rising edge.
- i_sync_rst  input  1  reset. Asynchronous, active-high; the port keeps the codebase name.
- if_s_axi4_lite  interface (slv_port modport)  —  AXI4-Lite slave bundle. The block drives awready, wready, bresp[1:0], bvalid, arready, rdata[DATA_WIDTH-1:0], rresp[1:0] and rvalid. All other bundle signals are inputs: awaddr, awprot, awvalid, wdata, wstrb[DATA_WIDTH/8-1:0], wvalid, bready, araddr, arprot, arvalid and rready. awprot and arprot are ignored.

## Operation
- Register index is addr[$clog2(NUM_REGS)+1:2]. addr[1:0] is ignored.
- An address is in range when addr < NUM_REGS*4. All other addresses are out of range.
- Write channel:
  - AW and W are accepted independently, and each is latched on its own handshake.
  - Once both are latched, the write is executed: byte k of the register is updated iff wstrb[k]=1, and bvalid is raised.
  - In-range write: bresp=OKAY (2'b00). Out-of-range write: no register changes, bresp=SLVERR (2'b10).
- Read channel:
  - On an AR handshake, rdata receives the register value and rvalid is raised.
  - In-range read: rresp=OKAY. Out-of-range read: rdata=0, rresp=SLVERR.
- Read and write paths are independent and may be active in the same cycle.
- When a read's AR handshake and a write's execution fall on the same edge to the same register, the read returns the pre-write value.
- Reset values, applied immediately on reset assertion:
  - All registers = 0.
  - awready, wready, arready, bvalid and rvalid = 0.
  - bresp, rresp and rdata = 0.
  - AW and W latches are cleared.
- Reset mid-transaction discards any pending AW, W, B or R. No response is issued for it afterwards.

## Timing
- awready, wready and arready are registered outputs. They rise on the first rising edge after reset deasserts.
- awready is high iff no AW is latched and no B is pending. wready follows the same rule for W.
- AW and W handshakes on the same edge N: register updated and bvalid=1 from edge N+1. awready and wready are 0 from N+1.
- AW at edge N, W at edge M>N: awready=0 from N+1. The write executes with bvalid=1 from M+1. The same applies with AW and W swapped.
- bvalid and bresp hold until bvalid&&bready. awready and wready return to 1 on the edge after the B handshake.
- AR handshake at edge N: rvalid=1 and rdata valid from N+1, arready=0 from N+1.
- rvalid, rdata and rresp hold until rvalid&&rready. arready returns to 1 on the edge after the R handshake.
- The block never deasserts a valid it drives before the matching ready.
- Minimum write-to-write spacing is 2 cycles with bready held high. Read-to-read spacing is the same with rready held high.

## Structure
- Package axi4_lite_slv_template_pkg holds:
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - A resp_t typedef.
  - A localparam computing the register index width from NUM_REGS.
- One sub-module, axi4_lite_slv_reg_file: NUM_REGS×32 storage with a strobed write port and an asynchronous read port.
- The AXI handshake FSM stays in the top module.

## Test plan
- Reset held 20 cycles, then released: all readys rise on the first edge after release, and bvalid and rvalid stay 0.
- Write 0x12345678, 0x87654321, 0xABCDEF01 and 0x10FEDCBA to 0x0, 0x4, 0x8 and 0xC with wstrb=4'hF, then read them back. Each bresp and rresp = OKAY, and the values read back match.
- Write 0xFFFFFFFF to 0x4, then write 0x0000AAAA to 0x4 with wstrb=4'b0011. Reading 0x4 returns 0xFFFFAAAA.
- Drive AW (0x8) 3 cycles before W (0x55AA55AA):
  - awready drops after the AW handshake.
  - A single write occurs, with bvalid on the edge after the W handshake.
  - Reading 0x8 returns 0x55AA55AA.
- Write to 0x10 and read from 0x10: bresp=SLVERR, rresp=SLVERR, rdata=0, and registers 0x0–0xC are unchanged.
- Hold bready=0 for 5 cycles after a write: bvalid stays 1 and awready/wready stay 0. Then assert reset: bvalid drops immediately and all registers read 0 after release.
